// File: rtl/controlador_engarrafamento.sv
// Bottling line sequencer: steps each bottle through advance, fill, cap and
// inspect, drives the conveyor, fill valve, capper and alarm, and keeps the
// cork stock plus the good-bottle / dozen / lot counters.
module controlador_engarrafamento #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CORK_MAX       = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_pulse,
    input  logic       cork_add,
    input  logic       PG,
    input  logic       CH,
    input  logic       RO,
    input  logic       CQ,
    output logic       MOTOR,
    output logic       EV,
    output logic       VE,
    output logic       ALARME,
    output logic       running,
    output logic [2:0] estado,
    output logic [6:0] rolhas,
    output logic [3:0] garrafas,
    output logic [3:0] duzias,
    output logic       lote_ok
);

    // Watchdog only has to reach TIMEOUT_CYCLES-1 before the state is left.
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]      CORK_FULL = 7'(CORK_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADVANCE = 3'd1,
        S_FILL    = 3'd2,
        S_CAP     = 3'd3,
        S_INSPECT = 3'd4,
        S_FAULT   = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic            running_q, running_d;
    logic [6:0]      rolhas_q, rolhas_d;
    logic [3:0]      garrafas_q, garrafas_d;
    logic [3:0]      duzias_q, duzias_d;
    logic            lote_ok_q, lote_ok_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            motor_q, ev_q, ve_q, alarme_q;

    logic            timedState;
    logic            wdExpired;
    logic            consume;
    logic            goodBottle;

    assign wdExpired  = (wd_q == WD_LIMIT);
    assign consume    = (state_q == S_CAP) && RO;
    assign goodBottle = (state_q == S_INSPECT) && !CQ;

    // Next-state decision: each timed phase leaves on its sensor, and the
    // watchdog only forces FAULT when the sensor is still low at the limit.
    always_comb begin
        state_d    = state_q;
        timedState = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (running_q) begin
                    state_d = (rolhas_q != 7'd0) ? S_ADVANCE : S_FAULT;
                end
            end
            S_ADVANCE: begin
                timedState = 1'b1;
                if (PG) begin
                    state_d = S_FILL;
                end else if (wdExpired) begin
                    state_d = S_FAULT;
                end
            end
            S_FILL: begin
                timedState = 1'b1;
                if (CH) begin
                    state_d = S_CAP;
                end else if (wdExpired) begin
                    state_d = S_FAULT;
                end
            end
            S_CAP: begin
                timedState = 1'b1;
                if (RO) begin
                    state_d = S_INSPECT;
                end else if (wdExpired) begin
                    state_d = S_FAULT;
                end
            end
            S_INSPECT: begin
                if (!running_q) begin
                    state_d = S_IDLE;
                end else if (rolhas_q != 7'd0) begin
                    state_d = S_ADVANCE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (start_pulse) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Run flag: start toggles it, except in FAULT where start acknowledges
    // the fault and leaves the line stopped.
    always_comb begin
        running_d = running_q;
        if (state_q == S_FAULT) begin
            if (start_pulse) begin
                running_d = 1'b0;
            end
        end else if (start_pulse) begin
            running_d = ~running_q;
        end
    end

    // Watchdog restarts on every state change and only runs in timed phases.
    always_comb begin
        wd_d = '0;
        if ((state_d == state_q) && timedState) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Cork stock: a simultaneous add and consume cancel out; adds saturate.
    always_comb begin
        rolhas_d = rolhas_q;
        if (cork_add && consume) begin
            rolhas_d = rolhas_q;
        end else if (cork_add && (rolhas_q != CORK_FULL)) begin
            rolhas_d = rolhas_q + 7'd1;
        end else if (consume) begin
            rolhas_d = rolhas_q - 7'd1;
        end
    end

    // Good bottles roll into dozens, dozens roll into a completed lot.
    always_comb begin
        garrafas_d = garrafas_q;
        duzias_d   = duzias_q;
        lote_ok_d  = 1'b0;
        if (goodBottle) begin
            if (garrafas_q == 4'd11) begin
                garrafas_d = 4'd0;
                if (duzias_q == 4'd9) begin
                    duzias_d  = 4'd0;
                    lote_ok_d = 1'b1;
                end else begin
                    duzias_d = duzias_q + 4'd1;
                end
            end else begin
                garrafas_d = garrafas_q + 4'd1;
            end
        end
    end

    // State, counters and actuator registers; actuators are decoded from the
    // upcoming state so they always match the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            running_q  <= 1'b0;
            rolhas_q   <= 7'd0;
            garrafas_q <= 4'd0;
            duzias_q   <= 4'd0;
            lote_ok_q  <= 1'b0;
            wd_q       <= '0;
            motor_q    <= 1'b0;
            ev_q       <= 1'b0;
            ve_q       <= 1'b0;
            alarme_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            rolhas_q   <= rolhas_d;
            garrafas_q <= garrafas_d;
            duzias_q   <= duzias_d;
            lote_ok_q  <= lote_ok_d;
            wd_q       <= wd_d;
            motor_q    <= (state_d == S_ADVANCE);
            ev_q       <= (state_d == S_FILL);
            ve_q       <= (state_d == S_CAP);
            alarme_q   <= (state_d == S_FAULT);
        end
    end

    assign MOTOR    = motor_q;
    assign EV       = ev_q;
    assign VE       = ve_q;
    assign ALARME   = alarme_q;
    assign running  = running_q;
    assign estado   = state_q;
    assign rolhas   = rolhas_q;
    assign garrafas = garrafas_q;
    assign duzias   = duzias_q;
    assign lote_ok  = lote_ok_q;

endmodule
